// File: rtl/wb_arb_stage_if.sv
// Writeback request bundle between the writeback sources and the arbitration stage.
// The stage receives requests and drives the grants plus the register-file write port.
interface wb_arb_stage_if #(
    parameter int NUM_CH = 2,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH-1:0]        in_mem2reg;
    logic [3*NUM_CH-1:0]      in_ldop;
    logic [2*NUM_CH-1:0]      in_boff;
    logic [32*NUM_CH-1:0]     in_alu;
    logic [32*NUM_CH-1:0]     in_ldata;
    logic [REG_AW*NUM_CH-1:0] in_dest;
    logic                     rf_we;
    logic [REG_AW-1:0]        rf_waddr;
    logic [31:0]              rf_wdata;
    logic                     done_out;
    logic [CNT_W-1:0]         retire_cnt;

    modport master (
        output in_valid, in_mem2reg, in_ldop, in_boff, in_alu, in_ldata, in_dest,
        input  in_ready, rf_we, rf_waddr, rf_wdata, done_out, retire_cnt
    );

    modport slave (
        input  in_valid, in_mem2reg, in_ldop, in_boff, in_alu, in_ldata, in_dest,
        output in_ready, rf_we, rf_waddr, rf_wdata, done_out, retire_cnt
    );
endinterface

// File: rtl/wb_arb_stage.sv
// Round-robin writeback arbiter with load extension feeding one register-file write port.
// Latency 1 cycle; grant is combinational from in_valid and the pointer, losers simply hold their request.
module wb_arb_stage #(
    parameter int NUM_CH = 2,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_arb_stage_if.slave bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  win;
    logic [NUM_CH-1:0] hi_req;
    logic [NUM_CH-1:0] grant;
    logic              any_vld;
    logic              xfer;

    logic              sel_m2r;
    logic [2:0]        sel_ldop;
    logic [1:0]        sel_boff;
    logic [31:0]       sel_alu;
    logic [31:0]       sel_ldata;
    logic [REG_AW-1:0] sel_dest;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [31:0]       ld_ext;
    logic [31:0]       wb_dat;

    logic              rf_we_q, rf_we_d;
    logic              done_q, done_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Lowest valid channel at or above the pointer wins; otherwise wrap to the lowest valid one.
    always_comb begin
        any_vld = |bus.in_valid;
        hi_req  = '0;
        win     = '0;
        grant   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hi_req[i] = bus.in_valid[i] && (i >= int'(ptr_q));
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) win = PTR_W'(i);
        end
        if (|hi_req) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (hi_req[i]) win = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i] = any_vld && rst_n && (win == PTR_W'(i));
        end
    end

    assign bus.in_ready = grant;
    assign xfer         = |grant;

    always_comb begin
        sel_m2r   = 1'b0;
        sel_ldop  = '0;
        sel_boff  = '0;
        sel_alu   = '0;
        sel_ldata = '0;
        sel_dest  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_m2r   = bus.in_mem2reg[i];
                sel_ldop  = bus.in_ldop[i*3 +: 3];
                sel_boff  = bus.in_boff[i*2 +: 2];
                sel_alu   = bus.in_alu[i*32 +: 32];
                sel_ldata = bus.in_ldata[i*32 +: 32];
                sel_dest  = bus.in_dest[i*REG_AW +: REG_AW];
            end
        end
    end

    // Halfword loads only look at boff[1]; reserved op codes fall through to a full word.
    always_comb begin
        ld_b = sel_ldata[{sel_boff, 3'b000} +: 8];
        ld_h = sel_boff[1] ? sel_ldata[31:16] : sel_ldata[15:0];
        case (sel_ldop)
            3'd0:    ld_ext = {{24{ld_b[7]}}, ld_b};
            3'd1:    ld_ext = {24'h0, ld_b};
            3'd2:    ld_ext = {{16{ld_h[15]}}, ld_h};
            3'd3:    ld_ext = {16'h0, ld_h};
            default: ld_ext = sel_ldata;
        endcase
        wb_dat = sel_m2r ? ld_ext : sel_alu;
    end

    always_comb begin
        ptr_d   = ptr_q;
        rf_we_d = 1'b0;
        done_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            ptr_d  = (win == PTR_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
            done_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            // x0 retires like any other request but never reaches the register file.
            if (sel_dest != '0) begin
                rf_we_d = 1'b1;
                waddr_d = sel_dest;
                wdata_d = wb_dat;
            end else begin
                waddr_d = '0;
                wdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            rf_we_q <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            rf_we_q <= rf_we_d;
            done_q  <= done_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = waddr_q;
    assign bus.rf_wdata   = wdata_q;
    assign bus.done_out   = done_q;
    assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_arb_stage.sv
// Bench for wb_arb_stage: scoreboard of expected register-file writes plus a round-robin reference.
// A second single-channel instance with a 4-bit counter exercises the retire counter wrap.
module tb_wb_arb_stage;
    logic clk;
    logic rst_n;

    wb_arb_stage_if #(.NUM_CH(2), .REG_AW(5), .CNT_W(32)) bus ();
    wb_arb_stage_if #(.NUM_CH(1), .REG_AW(5), .CNT_W(4))  bus_w ();

    wb_arb_stage #(.NUM_CH(2), .REG_AW(5), .CNT_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    wb_arb_stage #(.NUM_CH(1), .REG_AW(5), .CNT_W(4)) u_dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w.slave)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ptr  = 0;
    int   m_cnt  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_ch(input int ch, input logic m2r, input logic [2:0] op, input logic [1:0] boff,
                          input logic [31:0] alu, input logic [31:0] ldata, input logic [4:0] dest);
        bus.in_mem2reg[ch]       = m2r;
        bus.in_ldop[ch*3 +: 3]   = op;
        bus.in_boff[ch*2 +: 2]   = boff;
        bus.in_alu[ch*32 +: 32]  = alu;
        bus.in_ldata[ch*32 +: 32] = ldata;
        bus.in_dest[ch*5 +: 5]   = dest;
    endtask

    // Reference write for a channel, built from the stimulus the bench itself drove.
    function automatic exp_t model(input int ch);
        exp_t        e;
        logic [31:0] w;
        logic [31:0] r;
        logic [7:0]  b;
        logic [15:0] h;
        int          bo;
        w  = bus.in_ldata[ch*32 +: 32];
        bo = int'(bus.in_boff[ch*2 +: 2]);
        b  = 8'((w >> (8 * bo)) & 32'hFF);
        h  = (bo >= 2) ? w[31:16] : w[15:0];
        case (int'(bus.in_ldop[ch*3 +: 3]))
            0:       r = $unsigned(32'($signed(b)));
            1:       r = 32'(b);
            2:       r = $unsigned(32'($signed(h)));
            3:       r = 32'(h);
            default: r = w;
        endcase
        if (!bus.in_mem2reg[ch]) r = bus.in_alu[ch*32 +: 32];
        e.waddr = bus.in_dest[ch*5 +: 5];
        e.we    = (e.waddr != 5'd0);
        e.wdata = e.we ? r : 32'h0;
        if (!e.we) e.waddr = 5'd0;
        return e;
    endfunction

    // Advances one clock; the reference arbiter predicts the winner and queues its write.
    task automatic clock_edge();
        int w;
        int c;
        w = -1;
        for (int k = 0; k < 2; k++) begin
            c = (m_ptr + k) % 2;
            if (w < 0 && bus.in_valid[c]) w = c;
        end
        if (w >= 0) begin
            sb.push_back(model(w));
            m_ptr = (w + 1) % 2;
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        bus.in_valid = 2'b11;
        set_ch(0, 1'b0, 3'd0, 2'd0, 32'h0000_0011, 32'h0, 5'd7);
        set_ch(1, 1'b0, 3'd0, 2'd0, 32'h0000_0022, 32'h0, 5'd8);
        #1;
        checks++;
        if ({bus.in_ready, bus.rf_we, bus.done_out} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl: ready=%b we=%b done=%b required 00/0/0", bus.in_ready, bus.rf_we, bus.done_out);
        end
        checks++;
        if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'h0 || bus.retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_dat: waddr=%0d wdata=%h cnt=%0d required 0/0/0", bus.rf_waddr, bus.rf_wdata, bus.retire_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.done_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_noaccept: we=%b done=%b required 0/0", bus.rf_we, bus.done_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: ready=%b required 01", bus.in_ready);
        end
        clock_edge();
        bus.in_valid = 2'b00;
        checks++;
        if (bus.done_out !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL reset_first_xfer: done=%b queued=%0d required done=1", bus.done_out, sb.size());
        end else begin
            e = sb.pop_front();
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {e.we, e.waddr, e.wdata}) begin
                errors++;
                $display("FAIL reset_first_xfer: we=%b waddr=%0d wdata=%h required %b/%0d/%h",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.waddr, e.wdata);
            end
        end
        clock_edge();
    endtask

    task automatic test_alu_write();
        exp_t e;
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_ch(0, 1'b0, 3'd4, 2'd0, 32'h1234_5678, 32'hAAAA_AAAA, 5'd5);
        bus.in_valid = 2'b01;
        #1;
        checks++;
        if (bus.in_ready !== 2'b01) begin
            errors++;
            $display("FAIL alu_ready: ready=%b required 01", bus.in_ready);
        end
        clock_edge();
        bus.in_valid = 2'b00;
        checks++;
        if (bus.done_out !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL alu_write: done=%b queued=%0d required done=1", bus.done_out, sb.size());
        end else begin
            e = sb.pop_front();
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {e.we, e.waddr, e.wdata}) begin
                errors++;
                $display("FAIL alu_write: we=%b waddr=%0d wdata=%h required %b/%0d/%h",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.waddr, e.wdata);
            end
        end
        checks++;
        if (bus.retire_cnt !== 32'd1) begin
            errors++;
            $display("FAIL alu_cnt: cnt=%0d required 1", bus.retire_cnt);
        end
        clock_edge();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.done_out !== 1'b0 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL idle_hold: we=%b done=%b waddr=%0d wdata=%h required 0/0/5/12345678",
                     bus.rf_we, bus.done_out, bus.rf_waddr, bus.rf_wdata);
        end
    endtask

    task automatic test_load_extend();
        exp_t        e;
        logic [2:0]  ops[5]   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [1:0]  boffs[5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
        logic [31:0] want[5]  = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            set_ch(0, 1'b1, ops[i], boffs[i], 32'h5555_5555, 32'h80FF_7F01, 5'(10 + i));
            bus.in_valid = 2'b01;
            clock_edge();
            checks++;
            if (bus.done_out !== 1'b1 || sb.size() == 0) begin
                errors++;
                $display("FAIL load_%0d: done=%b queued=%0d required done=1", i, bus.done_out, sb.size());
            end else begin
                e = sb.pop_front();
                if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {e.we, e.waddr, e.wdata}) begin
                    errors++;
                    $display("FAIL load_%0d: we=%b waddr=%0d wdata=%h required %b/%0d/%h",
                             i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.waddr, e.wdata);
                end
            end
            checks++;
            if (bus.rf_wdata !== want[i]) begin
                errors++;
                $display("FAIL load_const_%0d: wdata=%h required %h", i, bus.rf_wdata, want[i]);
            end
        end
        bus.in_valid = 2'b00;
        clock_edge();
    endtask

    task automatic test_contention();
        exp_t       e;
        logic [1:0] want_rdy;
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_ch(0, 1'b0, 3'd4, 2'd0, 32'hA0A0_0000, 32'h0, 5'd1);
        set_ch(1, 1'b0, 3'd4, 2'd0, 32'hB1B1_1111, 32'h0, 5'd2);
        bus.in_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            want_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (bus.in_ready !== want_rdy) begin
                errors++;
                $display("FAIL rr_grant_%0d: ready=%b required %b", i, bus.in_ready, want_rdy);
            end
            clock_edge();
            checks++;
            if (bus.done_out !== 1'b1 || sb.size() == 0) begin
                errors++;
                $display("FAIL rr_write_%0d: done=%b queued=%0d required done=1", i, bus.done_out, sb.size());
            end else begin
                e = sb.pop_front();
                if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {e.we, e.waddr, e.wdata}) begin
                    errors++;
                    $display("FAIL rr_write_%0d: we=%b waddr=%0d wdata=%h required %b/%0d/%h",
                             i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.waddr, e.wdata);
                end
            end
        end
        bus.in_valid = 2'b00;
        checks++;
        if (bus.retire_cnt !== 32'd4) begin
            errors++;
            $display("FAIL rr_cnt: cnt=%0d required 4", bus.retire_cnt);
        end
        clock_edge();
    endtask

    task automatic test_x0();
        exp_t        e;
        logic [31:0] cnt_before;
        cnt_before = bus.retire_cnt;
        set_ch(1, 1'b0, 3'd4, 2'd0, 32'hDEAD_BEEF, 32'h0, 5'd0);
        bus.in_valid = 2'b10;
        clock_edge();
        bus.in_valid = 2'b00;
        checks++;
        if (bus.done_out !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL x0_write: done=%b queued=%0d required done=1", bus.done_out, sb.size());
        end else begin
            e = sb.pop_front();
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {e.we, e.waddr, e.wdata}) begin
                errors++;
                $display("FAIL x0_write: we=%b waddr=%0d wdata=%h required %b/%0d/%h",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.waddr, e.wdata);
            end
        end
        checks++;
        if (bus.retire_cnt !== cnt_before + 32'd1) begin
            errors++;
            $display("FAIL x0_cnt: cnt=%0d required %0d", bus.retire_cnt, cnt_before + 32'd1);
        end
        clock_edge();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        set_ch(0, 1'b0, 3'd4, 2'd0, 32'hC0C0_C0C0, 32'h0, 5'd3);
        set_ch(1, 1'b0, 3'd4, 2'd0, 32'hD1D1_D1D1, 32'h0, 5'd4);
        bus.in_valid = 2'b10;
        clock_edge();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.in_ready, bus.rf_we, bus.done_out, bus.rf_waddr, bus.rf_wdata, bus.retire_cnt} !== '0) begin
            errors++;
            $display("FAIL midreset_clear: ready=%b we=%b done=%b waddr=%0d wdata=%h cnt=%0d required all 0",
                     bus.in_ready, bus.rf_we, bus.done_out, bus.rf_waddr, bus.rf_wdata, bus.retire_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.done_out !== 1'b0 || bus.retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midreset_hold: we=%b done=%b cnt=%0d required 0/0/0", bus.rf_we, bus.done_out, bus.retire_cnt);
        end
        bus.in_valid = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 2'b01) begin
            errors++;
            $display("FAIL midreset_grant: ready=%b required 01", bus.in_ready);
        end
        clock_edge();
        bus.in_valid = 2'b00;
        checks++;
        if (bus.done_out !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL midreset_first: done=%b queued=%0d required done=1", bus.done_out, sb.size());
        end else begin
            e = sb.pop_front();
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {e.we, e.waddr, e.wdata}) begin
                errors++;
                $display("FAIL midreset_first: we=%b waddr=%0d wdata=%h required %b/%0d/%h",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.waddr, e.wdata);
            end
        end
        clock_edge();
    endtask

    task automatic test_wrap();
        checks++;
        if (bus_w.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_ready: ready=%b required 0", bus_w.in_ready);
        end
        bus_w.in_valid = 1'b1;
        #1;
        checks++;
        if (bus_w.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: ready=%b required 1", bus_w.in_ready);
        end
        for (int n = 1; n <= 17; n++) begin
            @(posedge clk);
            #1;
            if (n == 16) begin
                checks++;
                if (bus_w.retire_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL wrap_16: cnt=%0d required 0", bus_w.retire_cnt);
                end
            end
        end
        bus_w.in_valid = 1'b0;
        checks++;
        if (bus_w.retire_cnt !== 4'd1 || bus_w.rf_waddr !== 5'd3 || bus_w.rf_wdata !== 32'h0000_0777) begin
            errors++;
            $display("FAIL wrap_17: cnt=%0d waddr=%0d wdata=%h required 1/3/00000777",
                     bus_w.retire_cnt, bus_w.rf_waddr, bus_w.rf_wdata);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = '0;
        bus.in_mem2reg = '0;
        bus.in_ldop    = '0;
        bus.in_boff    = '0;
        bus.in_alu     = '0;
        bus.in_ldata   = '0;
        bus.in_dest    = '0;
        bus_w.in_valid   = 1'b0;
        bus_w.in_mem2reg = 1'b0;
        bus_w.in_ldop    = 3'd4;
        bus_w.in_boff    = 2'd0;
        bus_w.in_alu     = 32'h0000_0777;
        bus_w.in_ldata   = 32'h0;
        bus_w.in_dest    = 5'd3;

        test_reset();
        test_alu_write();
        test_load_extend();
        test_contention();
        test_x0();
        test_reset_mid();
        test_wrap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arb_stage.md
WB_ARB_STAGE -- requirements
Module: wb_arb_stage

Interface
REQ-001 Parameter NUM_CH, default 2: number of writeback source channels (legal 1..8).
REQ-002 Parameter REG_AW, default 5: register-file address width.
REQ-003 Parameter CNT_W, default 32: retire counter width.
REQ-004 Data width SHALL be fixed at 32 bits.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  NUM_CH  per-channel writeback request.
REQ-008 in_ready  out  NUM_CH  per-channel grant; transfer when in_valid[i] & in_ready[i].
REQ-009 in_mem2reg  in  NUM_CH  1 = write load data, 0 = write ALU result.
REQ-010 in_ldop  in  3*NUM_CH  load op per channel: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW.
REQ-011 in_boff  in  2*NUM_CH  load byte offset per channel.
REQ-012 in_alu  in  32*NUM_CH  ALU result per channel.
REQ-013 in_ldata  in  32*NUM_CH  raw aligned load word per channel.
REQ-014 in_dest  in  REG_AW*NUM_CH  destination register per channel.
REQ-015 rf_we  out  1  register-file write enable.
REQ-016 rf_waddr  out  REG_AW  register-file write address.
REQ-017 rf_wdata  out  32  register-file write data.
REQ-018 done_out  out  1  one-cycle retire pulse per accepted request.
REQ-019 retire_cnt  out  CNT_W  count of retired requests.

Function
REQ-020 At most one channel SHALL be granted per cycle; in_ready SHALL be one-hot or zero, and SHALL depend only on in_valid and the priority pointer (combinational).
REQ-021 Arbitration SHALL be round-robin: search starts at pointer ptr; winner w gets in_ready[w]=1; ptr <= (w+1) mod NUM_CH on a transfer; ptr unchanged when no channel is valid.
REQ-022 Channels not granted SHALL hold their request; no request is dropped.
REQ-023 Output is one registered stage: a transfer in cycle N SHALL drive rf_we/rf_waddr/rf_wdata/done_out in cycle N+1; latency exactly 1, throughput 1 per cycle.
REQ-024 in_mem2reg=0: rf_wdata = in_alu of the winner.
REQ-025 LB: byte at offset boff, sign-extended; LBU: same byte, zero-extended.
REQ-026 LH: halfword at boff[1] (boff[0] ignored), sign-extended; LHU: zero-extended.
REQ-027 LW and reserved codes 5..7: full word unmodified.
REQ-028 in_dest=0: transfer accepted, done_out=1, retire_cnt increments, rf_we=0 (x0 never written); rf_waddr=0, rf_wdata=0.
REQ-029 Cycle with no transfer: rf_we=0, done_out=0, rf_waddr and rf_wdata hold previous values.
REQ-030 retire_cnt SHALL increment by 1 per transfer and wrap from 2^CNT_W-1 to 0 without flag.
REQ-031 NUM_CH=1: ptr is constant 0; in_ready[0]=in_valid[0].

Reset
REQ-032 rst_n low SHALL immediately clear rf_we, done_out, rf_waddr, rf_wdata, retire_cnt, ptr to 0.
REQ-033 While rst_n is low in_ready SHALL be all zeros; a request pending at reset assertion is not accepted and produces no write.
REQ-034 After rst_n deasserts, the first rising edge SHALL accept requests normally with ptr=0.

Verification
REQ-035 Single ALU write: ch0 valid, mem2reg=0, dest=5, alu=0x1234_5678 -> next cycle rf_we=1, waddr=5, wdata=0x1234_5678, done_out=1, retire_cnt=1.
REQ-036 Load extend: ldata=0x80FF_7F01; LB boff=3 -> 0xFFFF_FF80; LBU boff=1 -> 0x0000_007F; LH boff=2 -> 0xFFFF_80FF; LHU boff=0 -> 0x0000_7F01; LW -> 0x80FF_7F01.
REQ-037 Contention: both channels valid 4 cycles from reset -> grants ch0, ch1, ch0, ch1; four consecutive rf_we pulses, retire_cnt=4.
REQ-038 x0 target: dest=0, alu=0xDEAD_BEEF -> rf_we=0, done_out=1, retire_cnt increments.
REQ-039 Reset mid-stream: rst_n low while ch1 valid -> outputs 0 immediately, in_ready=0; after release ch0 wins first.
REQ-040 Wrap: CNT_W=4, 17 transfers -> retire_cnt=1.
